// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
//  Bundles the hazard inputs and the pipeline-register controls that connect the
//  stall/flush sequencer to the rest of the 5-stage pipeline.
//  master: pipeline/decoder side. It drives the hazard information and md_ack, and
//          receives enables, flushes and status.
//  slave : the pipeline_ctrl sequencer.
//  Signals:
//   ex_mem_read, ex_rt          load in EX and its destination register
//   id_rs, id_rt, id_uses_rt    sources of the instruction in ID
//   ex_branch_taken             branch/jump resolved taken in EX
//   id_md_op, id_syscall        ID holds an MD-unit op / a syscall
//   md_ack                      MD unit done pulse
//   pc_en..memwb_en             pipeline register enables
//   ifid_flush, idex_flush      pipeline register clears
//   md_req, halted, err_timeout registered status
//   stall_cnt                   saturating stalled-cycle count (CNT_W bits)
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_branch_taken;
  logic             id_md_op;
  logic             id_syscall;
  logic             md_ack;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             md_req;
  logic             halted;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt, ex_branch_taken,
           id_md_op, id_syscall, md_ack,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           md_req, halted, err_timeout, stall_cnt
  );

  modport slave (
    input  ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt, ex_branch_taken,
           id_md_op, id_syscall, md_ack,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           md_req, halted, err_timeout, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Resolves load-use
//  hazards, taken-branch flushes, multi-cycle mult/div waits (md_req/md_ack) and the
//  syscall drain-then-halt sequence.
//  Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-low reset
//   bus  pipeline_ctrl_if.slave: hazard inputs in; enables, flushes, md_req,
//        halted, err_timeout and stall_cnt out
//  Parameters:
//   MD_TIMEOUT  MD_WAIT cycles allowed before err_timeout (1..65535)
//   CNT_W       width of stall_cnt
module pipeline_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input logic           clk,
  input logic           rst,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, MD_WAIT, DRAIN, HALT} state_t;

  localparam logic [15:0] TMO_LAST = 16'(MD_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [1:0]       drain_q, drain_d;
  logic             md_req_q, md_req_d;
  logic             err_q, err_d;
  logic             halted_q;
  logic [CNT_W-1:0] stall_q;

  logic load_use;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;

  // Register r0 is hardwired to zero, so a load into it never creates a hazard.
  assign load_use = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  // State register plus the registered status outputs and counters.
  // HALT is excluded from stall counting because the pipeline is frozen, not stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      tmo_q    <= '0;
      drain_q  <= '0;
      md_req_q <= 1'b0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      drain_q  <= drain_d;
      md_req_q <= md_req_d;
      err_q    <= err_d;
      halted_q <= (state_d == HALT);
      if (!pc_en && (state_q != HALT) && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  // Next-state logic. In RUN a taken branch outranks every ID-stage request because
  // the ID instruction is on the wrong path and is being flushed anyway.
  // In MD_WAIT an ack that arrives on the last allowed cycle still counts as success.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    drain_d  = drain_q;
    md_req_d = md_req_q;
    err_d    = err_q;
    case (state_q)
      RUN: begin
        if (bus.ex_branch_taken) begin
          state_d = RUN;
        end else if (load_use) begin
          state_d = RUN;
        end else if (bus.id_md_op) begin
          state_d  = MD_WAIT;
          md_req_d = 1'b1;
          tmo_d    = '0;
        end else if (bus.id_syscall) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      MD_WAIT: begin
        if (bus.md_ack) begin
          md_req_d = 1'b0;
          state_d  = RUN;
        end else if (tmo_q == TMO_LAST) begin
          err_d    = 1'b1;
          md_req_d = 1'b0;
          state_d  = HALT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd2)
          state_d = HALT;
        else
          drain_d = drain_q + 2'd1;
      end
      default: state_d = HALT;
    endcase
  end

  // Output logic. A stall freezes PC and IF/ID and pushes a bubble into ID/EX while
  // EX/MEM and MEM/WB keep retiring older instructions.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use || bus.id_md_op || bus.id_syscall) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      MD_WAIT: begin
        if (!bus.md_ack) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      DRAIN: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
      default: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
    endcase
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.md_req      = md_req_q;
  assign bus.halted      = halted_q;
  assign bus.err_timeout = err_q;
  assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//  Directed bench for pipeline_ctrl. Three instances share clock and reset:
//   dut      default parameters
//   dut_tmo  MD_TIMEOUT=4, for the mult/div timeout path
//   dut_sat  CNT_W=3, for stall counter saturation
//  Inputs change 1 time unit after the rising edge; outputs are sampled on the
//  falling edge.
module tb_pipeline_ctrl;

  localparam logic [6:0] CTL_RUN    = 7'b1111100;
  localparam logic [6:0] CTL_STALL  = 7'b0011101;
  localparam logic [6:0] CTL_BRANCH = 7'b1111111;
  localparam logic [6:0] CTL_HALT   = 7'b0000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  pipeline_ctrl_if #(.CNT_W(16)) b();
  pipeline_ctrl_if #(.CNT_W(16)) bt();
  pipeline_ctrl_if #(.CNT_W(3))  bs();

  pipeline_ctrl #(.MD_TIMEOUT(64), .CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(b));
  pipeline_ctrl #(.MD_TIMEOUT(4),  .CNT_W(16)) dut_tmo (.clk(clk), .rst(rst), .bus(bt));
  pipeline_ctrl #(.MD_TIMEOUT(64), .CNT_W(3))  dut_sat (.clk(clk), .rst(rst), .bus(bs));

  // Control outputs packed as {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}.
  wire [6:0] ctl_b = {b.pc_en, b.ifid_en, b.idex_en, b.exmem_en, b.memwb_en,
                      b.ifid_flush, b.idex_flush};
  wire [6:0] ctl_t = {bt.pc_en, bt.ifid_en, bt.idex_en, bt.exmem_en, bt.memwb_en,
                      bt.ifid_flush, bt.idex_flush};
  // Status packed as {md_req, halted, err_timeout}.
  wire [2:0] st_t  = {bt.md_req, bt.halted, bt.err_timeout};

  always #5 clk = ~clk;

  task next_cycle;
    @(posedge clk);
    #1;
  endtask

  task idle_all;
    b.ex_mem_read = 0; b.ex_rt = 0; b.id_rs = 0; b.id_rt = 0; b.id_uses_rt = 0;
    b.ex_branch_taken = 0; b.id_md_op = 0; b.id_syscall = 0; b.md_ack = 0;
    bt.ex_mem_read = 0; bt.ex_rt = 0; bt.id_rs = 0; bt.id_rt = 0; bt.id_uses_rt = 0;
    bt.ex_branch_taken = 0; bt.id_md_op = 0; bt.id_syscall = 0; bt.md_ack = 0;
    bs.ex_mem_read = 0; bs.ex_rt = 0; bs.id_rs = 0; bs.id_rt = 0; bs.id_uses_rt = 0;
    bs.ex_branch_taken = 0; bs.id_md_op = 0; bs.id_syscall = 0; bs.md_ack = 0;
  endtask

  task do_reset;
    idle_all();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
  endtask

  task set_hz(input logic rd, input logic [4:0] exrt, input logic [4:0] rs,
              input logic [4:0] rt, input logic uses, input logic br);
    b.ex_mem_read = rd; b.ex_rt = exrt; b.id_rs = rs; b.id_rt = rt;
    b.id_uses_rt = uses; b.ex_branch_taken = br;
  endtask

  // Reset values of all registered outputs and idle control outputs.
  task test_reset;
    idle_all();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (ctl_b !== CTL_RUN) begin
      tests_failed++; $display("[TB] FAIL reset_ctl: got %b expected %b", ctl_b, CTL_RUN);
    end
    tests_run++;
    if ({b.md_req, b.halted, b.err_timeout} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {b.md_req, b.halted, b.err_timeout});
    end
    tests_run++;
    if (b.stall_cnt !== 16'd0) begin
      tests_failed++; $display("[TB] FAIL reset_cnt: got %0d expected 0", b.stall_cnt);
    end
    rst = 1'b1;
    next_cycle();
  endtask

  // Load-use via rs and rt, plus the non-hazard cases (rt unused, r0, no load).
  task test_load_use;
    do_reset();
    set_hz(1, 8, 8, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (ctl_b !== CTL_STALL) begin
      tests_failed++; $display("[TB] FAIL lu_rs_ctl: got %b expected %b", ctl_b, CTL_STALL);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    tests_run++;
    if (ctl_b !== CTL_RUN) begin
      tests_failed++; $display("[TB] FAIL lu_release_ctl: got %b expected %b", ctl_b, CTL_RUN);
    end
    tests_run++;
    if (b.stall_cnt !== 16'd1) begin
      tests_failed++; $display("[TB] FAIL lu_cnt1: got %0d expected 1", b.stall_cnt);
    end
    next_cycle();
    set_hz(1, 9, 0, 9, 1, 0);
    @(negedge clk);
    tests_run++;
    if (ctl_b !== CTL_STALL) begin
      tests_failed++; $display("[TB] FAIL lu_rt_ctl: got %b expected %b", ctl_b, CTL_STALL);
    end
    next_cycle();
    set_hz(1, 9, 0, 9, 0, 0);
    @(negedge clk);
    tests_run++;
    if (ctl_b !== CTL_RUN) begin
      tests_failed++; $display("[TB] FAIL lu_rt_unused_ctl: got %b expected %b", ctl_b, CTL_RUN);
    end
    next_cycle();
    set_hz(1, 0, 0, 0, 1, 0);
    @(negedge clk);
    tests_run++;
    if (ctl_b !== CTL_RUN) begin
      tests_failed++; $display("[TB] FAIL lu_r0_ctl: got %b expected %b", ctl_b, CTL_RUN);
    end
    next_cycle();
    set_hz(0, 8, 8, 8, 1, 0);
    @(negedge clk);
    tests_run++;
    if (ctl_b !== CTL_RUN) begin
      tests_failed++; $display("[TB] FAIL lu_noload_ctl: got %b expected %b", ctl_b, CTL_RUN);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    tests_run++;
    if (b.stall_cnt !== 16'd2) begin
      tests_failed++; $display("[TB] FAIL lu_cnt2: got %0d expected 2", b.stall_cnt);
    end
    next_cycle();
  endtask

  // A taken branch outranks both a load-use hazard and an MD request.
  task test_branch_priority;
    do_reset();
    set_hz(1, 8, 8, 0, 0, 1);
    @(negedge clk);
    tests_run++;
    if (ctl_b !== CTL_BRANCH) begin
      tests_failed++; $display("[TB] FAIL br_over_lu: got %b expected %b", ctl_b, CTL_BRANCH);
    end
    next_cycle();
    set_hz(0, 0, 0, 0, 0, 1);
    b.id_md_op = 1;
    @(negedge clk);
    tests_run++;
    if (ctl_b !== CTL_BRANCH) begin
      tests_failed++; $display("[TB] FAIL br_over_md: got %b expected %b", ctl_b, CTL_BRANCH);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    tests_run++;
    if (b.md_req !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL br_no_mdreq: got %b expected 0", b.md_req);
    end
    tests_run++;
    if (b.stall_cnt !== 16'd0) begin
      tests_failed++; $display("[TB] FAIL br_cnt0: got %0d expected 0", b.stall_cnt);
    end
    next_cycle();
  endtask

  // MD op waits 5 cycles for ack (one with a stray branch), then resumes.
  task test_md_wait;
    int req_hi;
    req_hi = 0;
    do_reset();
    b.id_md_op = 1;
    @(negedge clk);
    tests_run++;
    if (ctl_b !== CTL_STALL) begin
      tests_failed++; $display("[TB] FAIL md_entry_ctl: got %b expected %b", ctl_b, CTL_STALL);
    end
    tests_run++;
    if (b.md_req !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL md_entry_req: got %b expected 0", b.md_req);
    end
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      b.ex_branch_taken = (i == 2);
      @(negedge clk);
      if (b.md_req === 1'b1) req_hi++;
      tests_run++;
      if (ctl_b !== CTL_STALL) begin
        tests_failed++; $display("[TB] FAIL md_wait_ctl[%0d]: got %b expected %b", i, ctl_b, CTL_STALL);
      end
      next_cycle();
    end
    b.ex_branch_taken = 0;
    b.md_ack = 1;
    @(negedge clk);
    tests_run++;
    if (ctl_b !== CTL_RUN) begin
      tests_failed++; $display("[TB] FAIL md_ack_ctl: got %b expected %b", ctl_b, CTL_RUN);
    end
    tests_run++;
    if (req_hi !== 5) begin
      tests_failed++; $display("[TB] FAIL md_req_cycles: got %0d expected 5", req_hi);
    end
    next_cycle();
    b.md_ack = 0;
    b.id_md_op = 0;
    @(negedge clk);
    tests_run++;
    if (b.md_req !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL md_req_drop: got %b expected 0", b.md_req);
    end
    tests_run++;
    if (b.stall_cnt !== 16'd6) begin
      tests_failed++; $display("[TB] FAIL md_cnt: got %0d expected 6", b.stall_cnt);
    end
    next_cycle();
    b.md_ack = 1;
    next_cycle();
    b.md_ack = 0;
    @(negedge clk);
    tests_run++;
    if ({ctl_b, b.md_req} !== {CTL_RUN, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL md_stray_ack: got %b expected %b", {ctl_b, b.md_req}, {CTL_RUN, 1'b0});
    end
    next_cycle();
  endtask

  // MD_TIMEOUT=4: four unanswered MD_WAIT cycles halt with err_timeout;
  // an ack on the fourth cycle wins over the timeout.
  task test_timeout;
    do_reset();
    bt.id_md_op = 1;
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (st_t !== 3'b100) begin
        tests_failed++; $display("[TB] FAIL tmo_wait_flags[%0d]: got %b expected 100", i, st_t);
      end
      next_cycle();
    end
    @(negedge clk);
    tests_run++;
    if (st_t !== 3'b011) begin
      tests_failed++; $display("[TB] FAIL tmo_halt_flags: got %b expected 011", st_t);
    end
    tests_run++;
    if (ctl_t !== CTL_HALT) begin
      tests_failed++; $display("[TB] FAIL tmo_halt_ctl: got %b expected %b", ctl_t, CTL_HALT);
    end
    tests_run++;
    if (bt.stall_cnt !== 16'd5) begin
      tests_failed++; $display("[TB] FAIL tmo_cnt: got %0d expected 5", bt.stall_cnt);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if ({bt.stall_cnt, bt.err_timeout} !== {16'd5, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL tmo_frozen: got cnt=%0d err=%b expected cnt=5 err=1", bt.stall_cnt, bt.err_timeout);
    end
    next_cycle();
    do_reset();
    bt.id_md_op = 1;
    next_cycle();
    for (int i = 0; i < 3; i++) next_cycle();
    bt.md_ack = 1;
    @(negedge clk);
    tests_run++;
    if (ctl_t !== CTL_RUN) begin
      tests_failed++; $display("[TB] FAIL tmo_ack_ctl: got %b expected %b", ctl_t, CTL_RUN);
    end
    next_cycle();
    bt.md_ack = 0;
    bt.id_md_op = 0;
    @(negedge clk);
    tests_run++;
    if (st_t !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL tmo_ack_flags: got %b expected 000", st_t);
    end
    next_cycle();
  endtask

  // Syscall drains for three cycles, halts, and only reset brings it back.
  task test_syscall;
    do_reset();
    b.id_syscall = 1;
    @(negedge clk);
    tests_run++;
    if (ctl_b !== CTL_STALL) begin
      tests_failed++; $display("[TB] FAIL sc_entry_ctl: got %b expected %b", ctl_b, CTL_STALL);
    end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({ctl_b, b.halted} !== {CTL_STALL, 1'b0}) begin
        tests_failed++; $display("[TB] FAIL sc_drain[%0d]: got %b expected %b", i, {ctl_b, b.halted}, {CTL_STALL, 1'b0});
      end
      next_cycle();
    end
    @(negedge clk);
    tests_run++;
    if ({ctl_b, b.halted} !== {CTL_HALT, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL sc_halt: got %b expected %b", {ctl_b, b.halted}, {CTL_HALT, 1'b1});
    end
    tests_run++;
    if (b.stall_cnt !== 16'd4) begin
      tests_failed++; $display("[TB] FAIL sc_cnt: got %0d expected 4", b.stall_cnt);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if ({ctl_b, b.stall_cnt} !== {CTL_HALT, 16'd4}) begin
      tests_failed++; $display("[TB] FAIL sc_halt_hold: got ctl=%b cnt=%0d expected ctl=%b cnt=4", ctl_b, b.stall_cnt, CTL_HALT);
    end
    rst = 1'b0;
    b.id_syscall = 0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({ctl_b, b.halted, b.stall_cnt} !== {CTL_RUN, 1'b0, 16'd0}) begin
      tests_failed++; $display("[TB] FAIL sc_reset: got ctl=%b halted=%b cnt=%0d expected ctl=%b halted=0 cnt=0", ctl_b, b.halted, b.stall_cnt, CTL_RUN);
    end
    next_cycle();
  endtask

  // Reset in the middle of MD_WAIT drops md_req at that reset edge.
  task test_reset_abort;
    do_reset();
    b.id_md_op = 1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (b.md_req !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL abort_req_before: got %b expected 1", b.md_req);
    end
    rst = 1'b0;
    b.id_md_op = 0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({ctl_b, b.md_req} !== {CTL_RUN, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL abort_req_drop: got %b expected %b", {ctl_b, b.md_req}, {CTL_RUN, 1'b0});
    end
    next_cycle();
  endtask

  // CNT_W=3: ten stalled cycles leave the counter pinned at 7.
  task test_saturate;
    do_reset();
    bs.ex_mem_read = 1;
    bs.ex_rt = 5'd5;
    bs.id_rs = 5'd5;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if (i == 6) begin
        @(negedge clk);
        tests_run++;
        if (bs.stall_cnt !== 3'd7) begin
          tests_failed++; $display("[TB] FAIL sat_reach: got %0d expected 7", bs.stall_cnt);
        end
        next_cycle();
        i++;
      end
    end
    @(negedge clk);
    tests_run++;
    if (bs.stall_cnt !== 3'd7) begin
      tests_failed++; $display("[TB] FAIL sat_hold: got %0d expected 7", bs.stall_cnt);
    end
    idle_all();
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (bs.stall_cnt !== 3'd7) begin
      tests_failed++; $display("[TB] FAIL sat_idle: got %0d expected 7", bs.stall_cnt);
    end
    next_cycle();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_load_use();
    test_branch_priority();
    test_md_wait();
    test_timeout();
    test_syscall();
    test_reset_abort();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    tests_failed++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
